// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDrop
  } fetch_state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam int unsigned DEFAULT_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with push/pop/flush and an occupancy count; flush wins over push and pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: sequential PC generation, single-outstanding memory request, and
// a PC-tagged instruction queue feeding decode, with redirect flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  output logic                   inst_valid,
  output logic [31:0]            inst_out,
  output logic [31:0]            inst_pc,
  input  logic                   inst_ready,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic [31:0]  redirect_word;
  logic         push, pop;
  logic         fifo_empty, fifo_full;
  logic [63:0]  fifo_rdata;

  assign redirect_word = word_align(redirect_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    unique case (state_q)
      StIdle: begin
        // Registered level gates issue, so a same-cycle pop cannot free a slot early.
        if (redirect) begin
          fetch_pc_d = redirect_word;
        end else if (level < FULL_LEVEL) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect) begin
          fetch_pc_d = redirect_word;
          if (mem_ack) begin
            state_d = StIdle;
          end else begin
            state_d     = StDrop;
            drop_addr_d = fetch_pc_q;
          end
        end else if (mem_ack) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = StIdle;
        end
      end
      StDrop: begin
        if (redirect) fetch_pc_d = redirect_word;
        if (mem_ack)  state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req  = (state_q != StIdle);
    mem_addr = (state_q == StDrop) ? drop_addr_q : fetch_pc_q;
    push     = (state_q == StWait) & mem_ack & ~redirect & ~fifo_full;
    pop      = inst_valid & inst_ready & ~redirect;
  end

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({fetch_pc_q, mem_rdata}),
    .pop   (pop),
    .flush (redirect),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (level)
  );

  assign inst_valid = ~fifo_empty;
  assign inst_pc    = fifo_rdata[63:32];
  assign inst_out   = fifo_rdata[31:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a variable-latency memory model.
module tb_fetch_queue;

  localparam logic [31:0] XOR_KEY = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst, rst2;
  logic        mem_req, mem_ack, mem_req2, mem_ack2;
  logic [31:0] mem_addr, mem_rdata, mem_addr2, mem_rdata2;
  logic        inst_valid, inst_ready, inst_valid2;
  logic [31:0] inst_out, inst_pc, inst_out2, inst_pc2;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  level, level2;

  int errors = 0;
  int checks = 0;
  int mem_lat = 1;
  int n;

  logic [31:0] req_log[$];
  logic [31:0] req_log2[$];
  logic [63:0] pop_log[$];

  fetch_queue u_dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .level       (level)
  );

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'hFFFF_FFF8)
  ) u_dut_wrap (
    .clk         (clk),
    .rst         (rst2),
    .mem_req     (mem_req2),
    .mem_addr    (mem_addr2),
    .mem_ack     (mem_ack2),
    .mem_rdata   (mem_rdata2),
    .inst_valid  (inst_valid2),
    .inst_out    (inst_out2),
    .inst_pc     (inst_pc2),
    .inst_ready  (1'b1),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .level       (level2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: acks after mem_lat cycles of continuous request, data = addr ^ key.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_ack = 1'b1;
          mem_rdata = mem_addr ^ XOR_KEY;
          req_log.push_back(mem_addr);
          cnt = 0;
        end
      end
    end
  end

  initial begin
    mem_ack2 = 1'b0;
    mem_rdata2 = '0;
    forever begin
      @(negedge clk);
      mem_ack2 = 1'b0;
      if (mem_req2) begin
        mem_ack2 = 1'b1;
        mem_rdata2 = mem_addr2 ^ XOR_KEY;
        req_log2.push_back(mem_addr2);
      end
    end
  end

  // Consumer monitor, sampled just before the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst && inst_valid && inst_ready && !redirect) pop_log.push_back({inst_pc, inst_out});
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect = 1'b0;
    @(negedge clk);
    req_log.delete();
    pop_log.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (mem_req2 !== 1'b0) begin errors++; $display("FAIL reset2_mem_req: got %b expected 0", mem_req2); end
    checks++; if (level2 !== 3'd0) begin errors++; $display("FAIL reset2_level: got %0d expected 0", level2); end
  endtask

  task automatic test_zero_wait();
    mem_lat = 1;
    inst_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'((i % 2) == 1)) begin
        errors++; $display("FAIL zw_valid_cycle%0d: got %b expected %b", i, inst_valid, (i % 2) == 1);
      end
    end
    @(negedge clk);
    checks++;
    if (req_log.size() < 4) begin
      errors++; $display("FAIL zw_req_count: got %0d expected >=4", req_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (req_log[i] !== 32'(i * 4)) begin
          errors++; $display("FAIL zw_addr%0d: got %h expected %h", i, req_log[i], 32'(i * 4));
        end
      end
    end
    checks++;
    if (pop_log.size() < 4) begin
      errors++; $display("FAIL zw_pop_count: got %0d expected >=4", pop_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pop_log[i] !== {32'(i * 4), 32'(i * 4) ^ XOR_KEY}) begin
          errors++; $display("FAIL zw_pop%0d: got %h expected %h", i, pop_log[i],
                             {32'(i * 4), 32'(i * 4) ^ XOR_KEY});
        end
      end
    end
  endtask

  task automatic test_fill_stall();
    mem_lat = 1;
    inst_ready = 1'b0;
    do_reset();
    n = 0;
    while (level !== 3'd4 && n < 20) begin @(negedge clk); n++; end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_timeout: level=%0d expected 4", level); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fill_req_full: got %b expected 0", mem_req); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fill_req_hold: got %b expected 0", mem_req); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level_hold: got %0d expected 4", level); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL fill_head_pc: got %h expected 0", inst_pc); end
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL pop_level: got %0d expected 3", level); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL pop_no_early_req: got %b expected 0", mem_req); end
    checks++; if (inst_pc !== 32'h4) begin errors++; $display("FAIL pop_head_pc: got %h expected 4", inst_pc); end
    checks++; if (inst_out !== (32'h4 ^ XOR_KEY)) begin errors++; $display("FAIL pop_head_inst: got %h expected %h", inst_out, 32'h4 ^ XOR_KEY); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL refill_req: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL refill_addr: got %h expected 10", mem_addr); end
    checks++; if (pop_log.size() !== 1) begin errors++; $display("FAIL pop_count: got %0d expected 1", pop_log.size()); end
  endtask

  task automatic test_redirect_drop();
    mem_lat = 5;
    inst_ready = 1'b0;
    do_reset();
    n = 0;
    while (level !== 3'd1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL drop_first_fill: level=%0d expected 1", level); end
    n = 0;
    while (mem_req !== 1'b1 && n < 5) begin @(negedge clk); n++; end
    checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL drop_second_addr: got %h expected 4", mem_addr); end
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL drop_req_held: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL drop_addr_held: got %h expected 4", mem_addr); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL drop_flush_level: got %0d expected 0", level); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL drop_flush_valid: got %b expected 0", inst_valid); end
    @(negedge clk);
    checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL drop_addr_held2: got %h expected 4", mem_addr); end
    n = 0;
    while (mem_req !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL drop_ack_timeout: mem_req=%b expected 0", mem_req); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL drop_data_discarded: level=%0d expected 0", level); end
    @(negedge clk);
    checks++; if (mem_addr !== 32'h100 || mem_req !== 1'b1) begin errors++; $display("FAIL drop_new_addr: got req=%b addr=%h expected 1/100", mem_req, mem_addr); end
    n = 0;
    while (inst_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (inst_pc !== 32'h100) begin errors++; $display("FAIL drop_new_pc: got %h expected 100", inst_pc); end
    checks++; if (inst_out !== (32'h100 ^ XOR_KEY)) begin errors++; $display("FAIL drop_new_inst: got %h expected %h", inst_out, 32'h100 ^ XOR_KEY); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL drop_new_level: got %0d expected 1", level); end
  endtask

  task automatic test_redirect_with_ack();
    mem_lat = 3;
    inst_ready = 1'b0;
    do_reset();
    n = 0;
    while (mem_req !== 1'b1 && n < 5) begin @(negedge clk); n++; end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rack_req_timeout: got %b expected 1", mem_req); end
    @(negedge clk);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h203;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rack_level: got %0d expected 0", level); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rack_valid: got %b expected 0", inst_valid); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rack_idle: got %b expected 0", mem_req); end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rack_new_req: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL rack_new_addr: got %h expected 200", mem_addr); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rack_level2: got %0d expected 0", level); end
  endtask

  task automatic test_pc_wrap();
    @(negedge clk);
    req_log2.delete();
    rst2 = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    checks++;
    if (req_log2.size() < 4) begin
      errors++; $display("FAIL wrap_req_count: got %0d expected >=4", req_log2.size());
    end else begin
      checks++; if (req_log2[0] !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_addr0: got %h expected fffffff8", req_log2[0]); end
      checks++; if (req_log2[1] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr1: got %h expected fffffffc", req_log2[1]); end
      checks++; if (req_log2[2] !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr2: got %h expected 00000000", req_log2[2]); end
      checks++; if (req_log2[3] !== 32'h0000_0004) begin errors++; $display("FAIL wrap_addr3: got %h expected 00000004", req_log2[3]); end
    end
  endtask

  task automatic test_async_reset();
    mem_lat = 3;
    inst_ready = 1'b0;
    do_reset();
    n = 0;
    while (level !== 3'd2 && n < 30) begin @(negedge clk); n++; end
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL ar_fill: level=%0d expected 2", level); end
    n = 0;
    while (mem_req !== 1'b1 && n < 5) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ar_mid_wait: got %b expected 1", mem_req); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ar_req_drop: got %b expected 0", mem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ar_valid_drop: got %b expected 0", inst_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL ar_level_drop: got %0d expected 0", level); end
    @(negedge clk);
    pop_log.delete();
    rst = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 5) begin @(negedge clk); n++; end
    checks++; if (mem_addr !== 32'h0 || mem_req !== 1'b1) begin errors++; $display("FAIL ar_restart_addr: got req=%b addr=%h expected 1/0", mem_req, mem_addr); end
    n = 0;
    while (inst_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL ar_restart_pc: got %h expected 0", inst_pc); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL ar_restart_level: got %0d expected 1", level); end
  endtask

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    inst_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    test_reset();
    test_zero_wait();
    test_fill_stall();
    test_redirect_drop();
    test_redirect_with_ack();
    test_pc_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
